pc_branch_ctrl: RTL and testbench
=================================

Name: pc_branch_ctrl

Overview:
- Consumes the 2-bit branch verdict from the decode-stage branch comparator and owns the program counter.
- Redirects fetch on a taken beq/bgt/blt, flushes the wrong-path instruction in IF/ID, and otherwise advances or holds the PC.
- Sits between the comparator (ID) and the instruction-memory address port (IF).

Parameters:
- ADDR_W, 16, PC / target width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- FLUSH_CYCLES, 1, cycles flush_ifid stays high after a redirect (1..3).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit hold: freezes the PC.
- id_valid  in  1  the IF/ID slot holds a live instruction.
- opCode  in  4  opcode of the instruction in ID.
- branch  in  2  comparator verdict: 2'b00 taken, 2'b01 not taken, 2'b1x reserved.
- id_pc  in  ADDR_W  address of the instruction in ID.
- br_offset  in  ADDR_W  sign-extended branch offset.
- pc_out  out  ADDR_W  current fetch address (registered).
- redirect  out  1  one-cycle pulse: pc_out was loaded with a branch target.
- flush_ifid  out  1  squash the IF/ID register contents.
- busy  out  1  FSM is in the FLUSH state.

Behaviour:
- Reset (asynchronous, any state): pc_out=RESET_PC, redirect=0, flush_ifid=0, busy=0, state=RUN, flush counter=0.
- is_br = opCode in {4'b0110 beq, 4'b0100 bgt, 4'b0101 blt}.
- take = id_valid & is_br & (branch==2'b00) & (state==RUN).
- Reserved verdicts 2'b10/2'b11 are treated as not taken.

FSM states:
- RUN
  - If take: pc_out <= id_pc + br_offset, truncated to ADDR_W bits (wraps modulo 2^ADDR_W). redirect=1 next cycle. Load counter with FLUSH_CYCLES. Go to FLUSH.
  - Else if stall: pc_out holds.
  - Else: pc_out <= pc_out + 1. 16'hFFFF wraps to 16'h0000.
- FLUSH
  - flush_ifid=1 and busy=1.
  - The counter decrements each cycle. When it reaches 1, return to RUN the next cycle.
  - pc_out advances by 1 per cycle unless stall is high.
  - Any branch in ID is a squashed wrong-path instruction: take is blocked, and its verdict is ignored.
  - Stall does not stop the counter.

Outputs and simultaneous events:
- flush_ifid and busy are registered. They rise on the cycle after the take edge and stay high for exactly FLUSH_CYCLES cycles.
- redirect is high for exactly one cycle, coincident with the new pc_out.
- Latency: verdict sampled at edge N; the target appears on pc_out after edge N.
- take together with stall: the redirect wins, the PC loads the target, and the stall is ignored for that edge.
- id_valid=0: no redirect regardless of branch or opCode.
- A non-branch opCode with branch=2'b00 causes no redirect.
- rst asserted during FLUSH: the flush is aborted immediately and all outputs return to their reset values.

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- Defined:
  - Adds outputs br_count[15:0] and taken_count[15:0].
  - br_count increments on each RUN-state cycle with id_valid & is_br.
  - taken_count increments on each take.
  - Both saturate at 16'hFFFF and reset to 0.
  - Not counted: squashed branches in FLUSH.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared cpu_pkg holds:
  - opcode constants OP_BEQ=4'b0110, OP_BGT=4'b0100, OP_BLT=4'b0101;
  - verdict constants BR_TAKEN=2'b00, BR_NOT_TAKEN=2'b01;
  - state enum {RUN, FLUSH}.
- The comparator and this block both import these constants.
- One sub-module: br_stat_counter, a saturating 16-bit counter with enable, instantiated twice under the macro.
- The FSM and PC register stay in the top module.

Test Plan:
- Reset release, no branches, stall=0, RESET_PC=0 -> pc_out 0,1,2,3 on successive cycles; flush_ifid=0.
- beq, id_valid=1, branch=00, id_pc=16'h0010, br_offset=16'h0005 -> next pc_out=16'h0015, redirect pulse of 1 cycle, flush_ifid high 1 cycle, then pc_out=16'h0016.
- blt taken with br_offset=16'hFFFC from id_pc=16'h0002 -> pc_out=16'hFFFE, then 16'hFFFF, then 16'h0000 (wrap).
- bgt taken while stall=1 -> target loaded, redirect=1. A second taken branch presented during FLUSH -> ignored; PC keeps incrementing.
- Non-branch opCode 4'b0001 with branch=00, and beq with branch=2'b11 -> no redirect; PC increments. With PC_BRANCH_STATS_EN, br_count +1 for the beq only, taken_count unchanged.
- FLUSH_CYCLES=3, rst pulsed during the 2nd flush cycle -> pc_out=RESET_PC and flush_ifid=0 immediately. After release: normal increment, counters (if enabled) =0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU decode constants: branch opcodes, comparator verdicts and the
// branch-control FSM state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_BEQ = 4'b0110;
  localparam logic [3:0] OP_BGT = 4'b0100;
  localparam logic [3:0] OP_BLT = 4'b0101;

  localparam logic [1:0] BR_TAKEN     = 2'b00;
  localparam logic [1:0] BR_NOT_TAKEN = 2'b01;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } br_state_e;

  function automatic logic is_branch_op(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BGT) || (op == OP_BLT);
  endfunction

endpackage

// File: rtl/br_stat_counter.sv
// Saturating 16-bit event counter with enable; holds at 16'hFFFF.
module br_stat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_branch_ctrl.sv
// Program counter owner: redirects fetch on taken beq/bgt/blt and flushes IF/ID.
// Optional branch statistics counters are enabled by defining PC_BRANCH_STATS_EN.
module pc_branch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned         ADDR_W       = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC     = '0,
  parameter int unsigned         FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              id_valid,
  input  logic [3:0]        opCode,
  input  logic [1:0]        branch,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [ADDR_W-1:0] br_offset,
  output logic [ADDR_W-1:0] pc_out,
  output logic              redirect,
  output logic              flush_ifid,
  output logic              busy
`ifdef PC_BRANCH_STATS_EN
  ,
  output logic [15:0]       br_count,
  output logic [15:0]       taken_count
`endif
);

  br_state_e         state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redirect_q, redirect_d;
  logic              flush_q, flush_d;
  logic              is_br;
  logic              take;

  assign is_br = is_branch_op(opCode);
  // Reserved verdicts 2'b1x never equal BR_TAKEN, so they fall through as not taken.
  assign take  = id_valid & is_br & (branch == BR_TAKEN) & (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    flush_d    = flush_q;
    case (state_q)
      RUN: begin
        if (take) begin
          pc_d       = id_pc + br_offset;
          redirect_d = 1'b1;
          cnt_d      = 2'(FLUSH_CYCLES);
          flush_d    = 1'b1;
          state_d    = FLUSH;
        end else if (!stall) begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      FLUSH: begin
        // The wrong-path slot is being squashed; stall only freezes the PC.
        if (!stall) begin
          pc_d = pc_q + ADDR_W'(1);
        end
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          flush_d = 1'b0;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        flush_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= 2'd0;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
    end
  end

  assign pc_out     = pc_q;
  assign redirect   = redirect_q;
  assign flush_ifid = flush_q;
  assign busy       = flush_q;

`ifdef PC_BRANCH_STATS_EN
  br_stat_counter u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (id_valid & is_br & (state_q == RUN)),
    .count (br_count)
  );

  br_stat_counter u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (take),
    .count (taken_count)
  );
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed scoreboard bench for pc_branch_ctrl: one DUT with a 1-cycle flush,
// one with a 3-cycle flush (used for the reset-during-flush case).
module tb_pc_branch_ctrl;
  import cpu_pkg::*;

  typedef struct {
    logic [15:0] pc;
    logic        r;
    logic        f;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_stall, a_valid, b_stall, b_valid;
  logic [3:0]  a_op, b_op;
  logic [1:0]  a_br, b_br;
  logic [15:0] a_idpc, a_off, b_idpc, b_off;
  logic [15:0] a_pc, b_pc;
  logic        a_redir, a_flush, a_busy, b_redir, b_flush, b_busy;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] a_brc, a_tkc, b_brc, b_tkc;
`endif

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_branch_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .stall(a_stall), .id_valid(a_valid), .opCode(a_op),
    .branch(a_br), .id_pc(a_idpc), .br_offset(a_off), .pc_out(a_pc),
    .redirect(a_redir), .flush_ifid(a_flush), .busy(a_busy)
`ifdef PC_BRANCH_STATS_EN
    , .br_count(a_brc), .taken_count(a_tkc)
`endif
  );

  pc_branch_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .stall(b_stall), .id_valid(b_valid), .opCode(b_op),
    .branch(b_br), .id_pc(b_idpc), .br_offset(b_off), .pc_out(b_pc),
    .redirect(b_redir), .flush_ifid(b_flush), .busy(b_busy)
`ifdef PC_BRANCH_STATS_EN
    , .br_count(b_brc), .taken_count(b_tkc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit sel, input logic st, input logic v, input logic [3:0] op,
                      input logic [1:0] br, input logic [15:0] ip, input logic [15:0] off,
                      input logic [15:0] epc, input logic er, input logic ef);
    exp_t e;
    if (!sel) begin
      a_stall = st; a_valid = v; a_op = op; a_br = br; a_idpc = ip; a_off = off;
    end else begin
      b_stall = st; b_valid = v; b_op = op; b_br = br; b_idpc = ip; b_off = off;
    end
    sb.push_back('{pc: epc, r: er, f: ef});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (!sel) begin
      chk("a_pc", 32'(a_pc), 32'(e.pc));
      chk("a_redirect", 32'(a_redir), 32'(e.r));
      chk("a_flush", 32'(a_flush), 32'(e.f));
      chk("a_busy", 32'(a_busy), 32'(e.f));
      $display("[TB] A op=%h br=%b v=%b st=%b -> pc=%h redir=%b flush=%b", op, br, v, st,
               a_pc, a_redir, a_flush);
    end else begin
      chk("b_pc", 32'(b_pc), 32'(e.pc));
      chk("b_redirect", 32'(b_redir), 32'(e.r));
      chk("b_flush", 32'(b_flush), 32'(e.f));
      chk("b_busy", 32'(b_busy), 32'(e.f));
      $display("[TB] B op=%h br=%b v=%b st=%b -> pc=%h redir=%b flush=%b", op, br, v, st,
               b_pc, b_redir, b_flush);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a_pc"}, 32'(a_pc), 32'h0);
    chk({tag, "_a_redir"}, 32'(a_redir), 32'h0);
    chk({tag, "_a_flush"}, 32'(a_flush), 32'h0);
    chk({tag, "_b_pc"}, 32'(b_pc), 32'h0);
    chk({tag, "_b_flush"}, 32'(b_flush), 32'h0);
    chk({tag, "_b_busy"}, 32'(b_busy), 32'h0);
  endtask

  initial begin
    a_stall = 0; a_valid = 0; a_op = 4'h0; a_br = 2'b01; a_idpc = 0; a_off = 0;
    b_stall = 0; b_valid = 0; b_op = 4'h0; b_br = 2'b01; b_idpc = 0; b_off = 0;
    #12;
    chk_reset("reset");
    rst = 1'b0;

    // Free-running increment after reset release
    step(0, 0, 0, 4'h0, 2'b01, 16'h0, 16'h0, 16'h0001, 0, 0);
    step(0, 0, 0, 4'h0, 2'b01, 16'h0, 16'h0, 16'h0002, 0, 0);
    step(0, 0, 0, 4'h0, 2'b01, 16'h0, 16'h0, 16'h0003, 0, 0);
    // beq taken: 0x10 + 5
    step(0, 0, 1, OP_BEQ, BR_TAKEN, 16'h0010, 16'h0005, 16'h0015, 1, 1);
    step(0, 0, 0, 4'h0, 2'b01, 16'h0, 16'h0, 16'h0016, 0, 0);
    // blt taken with negative offset, then wrap through 0xFFFF
    step(0, 0, 1, OP_BLT, BR_TAKEN, 16'h0002, 16'hFFFC, 16'hFFFE, 1, 1);
    step(0, 0, 0, 4'h0, 2'b01, 16'h0, 16'h0, 16'hFFFF, 0, 0);
    step(0, 0, 0, 4'h0, 2'b01, 16'h0, 16'h0, 16'h0000, 0, 0);
    // bgt taken during stall: redirect wins
    step(0, 1, 1, OP_BGT, BR_TAKEN, 16'h0100, 16'h0020, 16'h0120, 1, 1);
    // taken beq during FLUSH is squashed
    step(0, 0, 1, OP_BEQ, BR_TAKEN, 16'h0200, 16'h0004, 16'h0121, 0, 0);
    // plain stall holds the PC
    step(0, 1, 0, 4'h0, 2'b01, 16'h0, 16'h0, 16'h0121, 0, 0);
    // non-branch with taken verdict, reserved verdict, invalid slot
    step(0, 0, 1, 4'b0001, BR_TAKEN, 16'h0300, 16'h0010, 16'h0122, 0, 0);
    step(0, 0, 1, OP_BEQ, 2'b11, 16'h0300, 16'h0010, 16'h0123, 0, 0);
    step(0, 0, 0, OP_BEQ, BR_TAKEN, 16'h0300, 16'h0010, 16'h0124, 0, 0);
    a_valid = 0;
`ifdef PC_BRANCH_STATS_EN
    chk("a_br_count", 32'(a_brc), 32'd4);
    chk("a_taken_count", 32'(a_tkc), 32'd3);
`endif

    // Global reset before the 3-cycle-flush DUT checks
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    chk_reset("reset2");
`ifdef PC_BRANCH_STATS_EN
    chk("a_br_count_rst", 32'(a_brc), 32'd0);
    chk("a_taken_count_rst", 32'(a_tkc), 32'd0);
`endif

    step(1, 0, 0, 4'h0, 2'b01, 16'h0, 16'h0, 16'h0001, 0, 0);
    step(1, 0, 1, OP_BGT, BR_TAKEN, 16'h0040, 16'h0010, 16'h0050, 1, 1);
    // stall freezes the PC but not the flush counter
    step(1, 1, 0, 4'h0, 2'b01, 16'h0, 16'h0, 16'h0050, 0, 1);
    step(1, 0, 0, 4'h0, 2'b01, 16'h0, 16'h0, 16'h0051, 0, 1);
    step(1, 0, 0, 4'h0, 2'b01, 16'h0, 16'h0, 16'h0052, 0, 0);
    step(1, 0, 1, OP_BEQ, BR_TAKEN, 16'h0080, 16'h0008, 16'h0088, 1, 1);
    step(1, 0, 0, 4'h0, 2'b01, 16'h0, 16'h0, 16'h0089, 0, 1);
    // asynchronous reset in the 2nd flush cycle
    #2 rst = 1'b1;
    #1;
    chk("b_rst_pc", 32'(b_pc), 32'h0);
    chk("b_rst_flush", 32'(b_flush), 32'h0);
    chk("b_rst_busy", 32'(b_busy), 32'h0);
    chk("b_rst_redir", 32'(b_redir), 32'h0);
    #2 rst = 1'b0;
    step(1, 0, 0, 4'h0, 2'b01, 16'h0, 16'h0, 16'h0001, 0, 0);
    step(1, 0, 0, 4'h0, 2'b01, 16'h0, 16'h0, 16'h0002, 0, 0);
`ifdef PC_BRANCH_STATS_EN
    chk("b_br_count", 32'(b_brc), 32'd0);
    chk("b_taken_count", 32'(b_tkc), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
